// File: rtl/restoring_div_ctrl.sv
// Iterative unsigned restoring divider controller: one subtract/select row reused
// WIDTH times, with start/done handshake, operand capture and divide-by-zero path.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; result registers hold the last result
// RUN     | one quotient bit per clock, WIDTH iterations
// DONE    | done pulse; start here is accepted exactly as in IDLE
module restoring_div_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] qsh_q, qsh_d;
  logic [WIDTH-1:0] rem_acc_q, rem_acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sub;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] bor;
  logic             borrow_out;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Ripple borrow chain across the WIDTH+1 bit row; final borrow selects restore.
  always_comb begin
    trial = {rem_acc_q, qsh_q[WIDTH-1]};
    sub   = {1'b0, dvsr_q};
    diff  = '0;
    bor   = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      diff[i]  = trial[i] ^ sub[i] ^ bor[i];
      bor[i+1] = (~trial[i] & sub[i]) | (~(trial[i] ^ sub[i]) & bor[i]);
    end
    borrow_out = bor[WIDTH+1];
    r_next     = borrow_out ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    q_next     = {qsh_q[WIDTH-2:0], ~borrow_out};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvsr_d    = dvsr_q;
    qsh_d     = qsh_q;
    rem_acc_d = rem_acc_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d   = ST_RUN;
            busy_d    = 1'b1;
            dvsr_d    = divisor;
            qsh_d     = dividend;
            rem_acc_d = '0;
            cnt_d     = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        rem_acc_d = r_next;
        qsh_d     = q_next;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          quo_d   = q_next;
          rem_d   = r_next;
          dbz_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dvsr_q    <= '0;
      qsh_q     <= '0;
      rem_acc_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvsr_q    <= dvsr_d;
      qsh_q     <= qsh_d;
      rem_acc_q <= rem_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
